// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Used by load_store_unit and lsu_byte_lane.
package lsu_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } lsu_state_t;
endpackage

// File: rtl/lsu_byte_lane.sv
// Load lane extraction with sign/zero extension,
// and store lane merge for read-modify-write.
module lsu_byte_lane
    import lsu_pkg::*;
#(
    parameter int W  = 32,
    parameter int BA = 2
) (
    input  logic [W-1:0]  rword,
    input  logic [BA-1:0] off,
    input  size_t         size,
    input  logic          uns,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  ext,
    output logic [W-1:0]  merged
);
    logic [BYTE_W-1:0]   b;
    logic [2*BYTE_W-1:0] h;

    always_comb begin
        b      = rword[BYTE_W*off +: BYTE_W];
        h      = rword[2*BYTE_W*off[BA-1:1] +: 2*BYTE_W];
        ext    = rword;
        merged = wdata;
        unique case (size)
            SZ_BYTE: begin
                ext = uns ? W'(b) : {{(W-BYTE_W){b[BYTE_W-1]}}, b};
                merged = rword;
                merged[BYTE_W*off +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                ext = uns ? W'(h) : {{(W-2*BYTE_W){h[2*BYTE_W-1]}}, h};
                merged = rword;
                merged[2*BYTE_W*off[BA-1:1] +: 2*BYTE_W] =
                    wdata[2*BYTE_W-1:0];
            end
            default: begin
                ext    = rword;
                merged = wdata;
            end
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store initiator for a single-port word memory.
// Define LSU_STATS_EN to add saturating load/store/error counters.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int W  = 32,
    parameter int N  = 5,
    parameter int BA = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic [N-1:0] address,
    output logic         MemRead,
    output logic         MemWrite,
    output logic [W-1:0] write_data,
    input  logic [W-1:0] read_data
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]  stat_loads,
    output logic [15:0]  stat_stores,
    output logic [15:0]  stat_errors
`endif
);
    lsu_state_t    state, nxt;
    logic          wr_q, uns_q, err_q;
    size_t         size_q;
    logic [W-1:0]  wdata_q, word_q, rdata_q;
    logic [N-1:0]  idx_q;
    logic [BA-1:0] off_q;
    logic [W-1:0]  ext, merged;
    logic          accept, bad;
    logic [N-1:0]  idx_in;
    logic [BA-1:0] off_in;
    size_t         sz_in;

    assign idx_in = req_addr[BA+N-1:BA];
    assign off_in = req_addr[BA-1:0];
    assign sz_in  = size_t'(req_size);
    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        bad = 1'b0;
        unique case (sz_in)
            SZ_ILL:  bad = 1'b1;
            SZ_HALF: bad = off_in[0];
            SZ_WORD: bad = |off_in;
            default: bad = 1'b0;
        endcase
        if (int'(idx_in) >= N) bad = 1'b1;
        if (|req_addr[W-1:BA+N]) bad = 1'b1;
    end

    lsu_byte_lane #(.W(W), .BA(BA)) u_lane (
        .rword  (read_data),
        .off    (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .wdata  (wdata_q),
        .ext    (ext),
        .merged (merged)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (req_valid) begin
                if (bad)                                nxt = RESP;
                else if (!req_write || sz_in != SZ_WORD) nxt = RD;
                else                                    nxt = WR;
            end
            RD:      nxt = CAP;
            CAP:     nxt = wr_q ? WR : RESP;
            WR:      nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
            off_q   <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                wr_q    <= req_write;
                uns_q   <= req_unsigned;
                size_q  <= sz_in;
                wdata_q <= req_wdata;
                word_q  <= req_wdata;
                idx_q   <= idx_in;
                off_q   <= off_in;
                err_q   <= bad;
                rdata_q <= '0;
            end
            // Loads capture the extended lane; sub-word stores build the merge.
            if (state == CAP) begin
                if (wr_q) word_q  <= merged;
                else      rdata_q <= ext;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign MemRead    = (state == RD);
    assign MemWrite   = (state == WR);
    assign address    = (state == RD || state == WR) ? idx_q : '0;
    assign write_data = (state == WR) ? word_q : '0;
    assign rsp_valid  = (state == RESP);
    assign rsp_err    = (state == RESP) && err_q;
    assign rsp_rdata  = (state == RESP) ? rdata_q : '0;

`ifdef LSU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errors <= '0;
        end else if (state == RESP) begin
            if (err_q) begin
                if (stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
            end else if (wr_q) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, scoreboard queue,
// and hand sequences for reset abort and back-to-back requests.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  address;
    logic        MemRead, MemWrite;
    logic [31:0] write_data, read_data;
`ifdef LSU_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .address      (address),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .write_data   (write_data),
        .read_data    (read_data)
`ifdef LSU_STATS_EN
        ,
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_errors  (stat_errors)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4];
    always @(posedge clk) begin
        if (MemRead && address < 5) read_data <= mem[address];
        if (MemWrite && address < 5) mem[address] <= write_data;
    end

    int total = 0;
    int bad = 0;
    int nrd, nwr, nrsp;
    logic [4:0]  waddr;
    logic [31:0] wdat;

    always @(negedge clk) begin
        if (MemRead) nrd++;
        if (MemWrite) begin
            nwr++;
            waddr = address;
            wdat  = write_data;
        end
        if (rsp_valid) nrsp++;
        if (MemRead || MemWrite) begin
            total++;
            if (MemRead && MemWrite) begin
                bad++;
                $display("FAIL rd_wr_excl: both enables high at %0t", $time);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [4:0]  wa;
        logic [31:0] wdat;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic uns,
                                logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rd, logic err, int lat,
                                int r, int w, logic [4:0] wa,
                                logic [31:0] wdt);
        vec_t v;
        v.wr = wr; v.sz = sz; v.uns = uns; v.addr = a; v.wd = wd;
        v.rd = rd; v.err = err; v.lat = lat; v.nrd = r; v.nwr = w;
        v.wa = wa; v.wdat = wdt;
        return v;
    endfunction

    task automatic drive(input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic wait_rsp(output int lat);
        bit ok;
        lat = 0;
        ok  = 0;
        repeat (20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                ok = 1;
                break;
            end
            chk("busy_ready", 32'(req_ready), 32'd0);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: got none expected rsp_valid");
        end
    endtask

    task automatic check_pop(input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got response expected none");
            return;
        end
        e = sb.pop_front();
        chk("rdata", rsp_rdata, e.rd);
        chk("err", 32'(rsp_err), 32'(e.err));
        chk("latency", 32'(lat), 32'(e.lat));
    endtask

    task automatic run(input vec_t v);
        int lat;
        exp_t e;
        @(negedge clk);
        nrd = 0;
        nwr = 0;
        drive(v.wr, v.sz, v.uns, v.addr, v.wd);
        chk("idle_ready", 32'(req_ready), 32'd1);
        e.rd = v.rd; e.err = v.err; e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(lat);
        check_pop(lat);
        chk("n_reads", 32'(nrd), 32'(v.nrd));
        chk("n_writes", 32'(nwr), 32'(v.nwr));
        if (v.nwr > 0) begin
            chk("wr_addr", 32'(waddr), 32'(v.wa));
            chk("wr_data", wdat, v.wdat);
        end
    endtask

    initial begin
        int lat;
        exp_t e;
        for (int i = 0; i < 5; i++) mem[i] = '0;
        read_data = '0;
        rst = 1'b1;
        drive(0, 2'b00, 0, 0, 0);
        req_valid = 1'b0;

        vt.push_back(mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0, 0, 2, 0, 1, 2, 32'hDEADBEEF));
        vt.push_back(mk(0, 2'b00, 0, 32'h0B, 0, 32'hFFFFFFDE, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 2'b00, 1, 32'h0B, 0, 32'h000000DE, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(1, 2'b00, 0, 32'h09, 32'h55, 0, 0, 4, 1, 1, 2, 32'hDEAD55EF));
        vt.push_back(mk(0, 2'b10, 0, 32'h08, 0, 32'hDEAD55EF, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 2'b01, 0, 32'h0A, 0, 32'hFFFFDEAD, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 2'b01, 1, 32'h08, 0, 32'h000055EF, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(1, 2'b01, 0, 32'h0A, 32'hFFFF1234, 0, 0, 4, 1, 1, 2, 32'h123455EF));
        vt.push_back(mk(0, 2'b00, 0, 32'h09, 0, 32'h00000055, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 2'b00, 0, 32'h08, 0, 32'hFFFFFFEF, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 2'b01, 0, 32'h05, 0, 0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 2'b10, 0, 32'h06, 0, 0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'b10, 0, 32'h06, 32'hFFFFFFFF, 0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 2'b10, 0, 32'h14, 0, 0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 2'b11, 0, 32'h00, 0, 0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 2'b10, 0, 32'h100, 0, 0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'b00, 0, 32'h17, 32'h11, 0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 2'b10, 0, 32'h10, 32'hCAFEF00D, 0, 0, 2, 0, 1, 4, 32'hCAFEF00D));
        vt.push_back(mk(0, 2'b01, 1, 32'h12, 0, 32'h0000CAFE, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(0, 2'b01, 0, 32'h12, 0, 32'hFFFFCAFE, 0, 3, 1, 0, 0, 0));
        vt.push_back(mk(1, 2'b00, 0, 32'h13, 32'hAB, 0, 0, 4, 1, 1, 4, 32'hABFEF00D));
        vt.push_back(mk(0, 2'b00, 1, 32'h13, 0, 32'h000000AB, 0, 3, 1, 0, 0, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_memread", 32'(MemRead), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        rst = 1'b0;

        foreach (vt[i]) run(vt[i]);

        // Reset lands during CAP of a sub-word store.
        @(negedge clk);
        nwr  = 0;
        nrsp = 0;
        drive(1, 2'b00, 0, 32'h09, 32'h77);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_rd", 32'(MemRead), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_writes", 32'(nwr), 32'd0);
        chk("abort_rsps", 32'(nrsp), 32'd0);
        chk("abort_mem", mem[2], 32'h123455EF);
        run(mk(0, 2'b10, 0, 32'h08, 0, 32'h123455EF, 0, 3, 1, 0, 0, 0));

        // Back-to-back with req_valid held high.
        @(negedge clk);
        drive(0, 2'b10, 0, 32'h10, 0);
        e.rd = 32'hABFEF00D; e.err = 0; e.lat = 3;
        sb.push_back(e);
        @(posedge clk);
        wait_rsp(lat);
        check_pop(lat);
        drive(0, 2'b00, 1, 32'h10, 0);
        e.rd = 32'h0000000D; e.err = 0; e.lat = 3;
        sb.push_back(e);
        @(negedge clk);
        chk("b2b_ready", 32'(req_ready), 32'd1);
        chk("b2b_gap", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(lat);
        check_pop(lat);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
